// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receiver: legal oversampling ratios, frame bit
// indices and the bit-counter saturation point, plus a 3-input majority helper.
package uart_rx_pkg;

    localparam int PRESCALE_8       = 8;
    localparam int PRESCALE_16      = 16;
    localparam int PRESCALE_32      = 32;
    localparam int PRESCALE_DEFAULT = PRESCALE_8;

    localparam int BIT_START      = 0;
    localparam int BIT_DATA_LAST  = 8;
    localparam int BIT_PARITY     = 9;
    localparam int BIT_STOP_NOPAR = 9;
    localparam int BIT_STOP_PAR   = 10;

    localparam int BITCNT_SAT = 15;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Edge/bit counters for the UART receiver, including prescale legalisation
// (anything other than 8/16/32 runs as 8).
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int BITCNT_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  counter_en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] p_eff,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BITCNT_W-1:0]   bit_cnt
);

    localparam logic [BITCNT_W-1:0]   BIT_SAT  = BITCNT_W'(BITCNT_SAT);
    localparam logic [PRESCALE_W-1:0] EDGE_ONE = PRESCALE_W'(1);
    localparam logic [BITCNT_W-1:0]   BIT_ONE  = BITCNT_W'(1);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BITCNT_W-1:0]   bit_cnt_q, bit_cnt_d;

    always_comb begin
        case (prescale)
            PRESCALE_W'(PRESCALE_16): p_eff = PRESCALE_W'(PRESCALE_16);
            PRESCALE_W'(PRESCALE_32): p_eff = PRESCALE_W'(PRESCALE_32);
            default:                  p_eff = PRESCALE_W'(PRESCALE_DEFAULT);
        endcase
    end

    // A falling counter_en clears both counters even on a wrap edge.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (!counter_en) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (edge_cnt_q == (p_eff - EDGE_ONE)) begin
            edge_cnt_d = '0;
            if (bit_cnt_q != BIT_SAT) begin
                bit_cnt_d = bit_cnt_q + BIT_ONE;
            end
        end else begin
            edge_cnt_d = edge_cnt_q + EDGE_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// UART RX timing/sampling stage: edge/bit counters plus mid-bit sampling of ser_data.
// UART_RX_SAMP_MAJORITY_EN selects a 3-sample majority vote; otherwise one sample at H+1.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int BITCNT_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  counter_en,
    input  logic                  data_samp_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  ser_data,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BITCNT_W-1:0]   bit_cnt,
    output logic                  sampled_bit,
    output logic                  samp_valid
);

    localparam logic [PRESCALE_W-1:0] EDGE_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] p_eff;
    logic [PRESCALE_W-1:0] half;
    logic                  at_last;
    logic                  samp_active;
    logic                  vote_ready;
    logic                  vote_value;

    logic sampled_bit_q, sampled_bit_d;
    logic samp_valid_q, samp_valid_d;

    uart_rx_edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BITCNT_W   (BITCNT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .counter_en (counter_en),
        .prescale   (prescale),
        .p_eff      (p_eff),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt)
    );

    assign half        = p_eff >> 1;
    assign at_last     = (edge_cnt == (half + EDGE_ONE));
    assign samp_active = counter_en && data_samp_en;

`ifdef UART_RX_SAMP_MAJORITY_EN
    logic at_first, at_mid;
    logic s0_q, s0_d, s1_q, s1_d;
    // ok flags track an unbroken capture chain; any gap in data_samp_en voids the vote.
    logic s0_ok_q, s0_ok_d, s1_ok_q, s1_ok_d;

    assign at_first = (edge_cnt == (half - EDGE_ONE));
    assign at_mid   = (edge_cnt == half);

    always_comb begin
        s0_d    = s0_q;
        s1_d    = s1_q;
        s0_ok_d = s0_ok_q;
        s1_ok_d = s1_ok_q;
        if (!counter_en) begin
            s0_d    = 1'b1;
            s1_d    = 1'b1;
            s0_ok_d = 1'b0;
            s1_ok_d = 1'b0;
        end else if (!data_samp_en) begin
            s0_ok_d = 1'b0;
            s1_ok_d = 1'b0;
        end else begin
            if (at_first) begin
                s0_d    = ser_data;
                s0_ok_d = 1'b1;
            end
            if (at_mid) begin
                s1_d    = ser_data;
                s1_ok_d = s0_ok_q;
            end
            if (at_last) begin
                s0_ok_d = 1'b0;
                s1_ok_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            s0_ok_q <= 1'b0;
            s1_ok_q <= 1'b0;
        end else begin
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            s0_ok_q <= s0_ok_d;
            s1_ok_q <= s1_ok_d;
        end
    end

    assign vote_ready = s1_ok_q;
    assign vote_value = maj3(s0_q, s1_q, ser_data);
`else
    assign vote_ready = 1'b1;
    assign vote_value = ser_data;
`endif

    always_comb begin
        sampled_bit_d = sampled_bit_q;
        samp_valid_d  = 1'b0;
        if (samp_active && at_last && vote_ready) begin
            sampled_bit_d = vote_value;
            samp_valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sampled_bit_q <= 1'b1;
            samp_valid_q  <= 1'b0;
        end else begin
            sampled_bit_q <= sampled_bit_d;
            samp_valid_q  <= samp_valid_d;
        end
    end

    assign sampled_bit = sampled_bit_q;
    assign samp_valid  = samp_valid_q;

endmodule
